// File: rtl/sdram_rd_checker.sv
// sdram_rd_checker: read-side pattern checker for the SDRAM controller RD1 FIFO.
// On start it rewinds the read FIFO, pops DEPTH words one at a time and compares
// each against the incrementing pattern {8'h00, START_VAL+i} laid down by the
// write side. It reports pass/fail, a saturating error count, the first
// mismatch, and a value for the four seven-segment digits.
module sdram_rd_checker #(
  parameter int DEPTH     = 16,
  parameter int START_VAL = 0,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk_27m,
  input  logic        rst,
  input  logic        start,
  input  logic        rd_ready,
  input  logic [15:0] rd_data,
  output logic        rd_load,
  output logic        rd_req,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [7:0]  first_err_idx,
  output logic [15:0] first_err_data,
  output logic [15:0] display
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] START_V8 = 8'(START_VAL);
  localparam logic [7:0] DEPTH_V8 = 8'(DEPTH);
  localparam logic [7:0] IDX_LAST = 8'(DEPTH - 1);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  index;
  logic [9:0]  tmo_cnt;
  logic [2:0]  lat_cnt;
  logic [7:0]  exp_low;
  logic        mismatch;
  logic [7:0]  err_nxt;

  // Saturating increment so a long all-bad run parks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  // Expected word for the current index; 8-bit pattern arithmetic wraps.
  always_comb begin
    exp_low  = START_V8 + index;
    mismatch = (rd_data != {8'h00, exp_low});
    err_nxt  = sat_inc(err_cnt, mismatch);
  end

  // Strobes decode straight from state: the pop has to land in the very cycle
  // rd_ready is seen, and a reset drops both strobes on the same edge.
  always_comb begin
    rd_load = (state == S_LOAD);
    rd_req  = (state == S_REQ) && rd_ready;
  end

  // Run sequencing, counters and result capture.
  always_ff @(posedge clk_27m) begin
    if (rst) begin
      state          <= S_IDLE;
      index          <= 8'd0;
      tmo_cnt        <= 10'd0;
      lat_cnt        <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= 8'd0;
      first_err_idx  <= 8'd0;
      first_err_data <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_LOAD;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= 8'd0;
            first_err_idx  <= 8'd0;
            first_err_data <= 16'd0;
            index          <= 8'd0;
            tmo_cnt        <= 10'd0;
            lat_cnt        <= 3'd0;
          end
        end
        S_LOAD: begin
          state   <= S_REQ;
          tmo_cnt <= 10'd0;
        end
        S_REQ: begin
          if (rd_ready) begin
            tmo_cnt <= 10'd0;
            lat_cnt <= 3'd0;
            state   <= S_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
            tmo_cnt <= 10'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            err_cnt <= err_nxt;
            if (mismatch && (err_cnt == 8'd0)) begin
              first_err_idx  <= index;
              first_err_data <= rd_data;
            end
            index <= index + 8'd1;
            if (index == IDX_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == 8'd0);
            end else begin
              state <= S_REQ;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Seven-segment value: progress while idle/running, verdict once done.
  always_comb begin
    display = {8'h00, index};
    if (state == S_DONE) begin
      if (pass)                  display = {8'h00, DEPTH_V8};
      else if (err_cnt != 8'd0)  display = first_err_data;
      else                       display = 16'hDEAD;
    end
  end

endmodule
